// File: rtl/hdb3_pkg.sv
// Shared definitions for the HDB3/B3ZS zero-substitution path.
// Symbol encoding is {pos,neg}; polarity bit is 0 = +, 1 = -.
package hdb3_pkg;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_ZERO = 2'b00;
    localparam sym_t SYM_POS  = 2'b10;
    localparam sym_t SYM_NEG  = 2'b01;

    localparam int NZ_HDB3 = 4;
    localparam int NZ_B3ZS = 3;

    typedef enum logic {
        POL_POS = 1'b0,
        POL_NEG = 1'b1
    } pol_e;

    // Line symbol carrying a pulse of the given polarity.
    function automatic sym_t pol2sym(input logic pol);
        return pol ? SYM_NEG : SYM_POS;
    endfunction

endpackage

// File: rtl/hdb3dline.sv
// NZ-deep 2-bit symbol shift line with async reset.
// Ports: clk, rst (async, active-high); i_head loads stg[0] every cycle;
// i_tail_ld/i_tail override the shift into stg[NZ-1]; o_stg exposes all stages.
module hdb3dline
    import hdb3_pkg::*;
#(
    parameter int NZ = NZ_HDB3
) (
    input  logic              clk,
    input  logic              rst,
    input  sym_t              i_head,
    input  logic              i_tail_ld,
    input  sym_t              i_tail,
    output sym_t [NZ-1:0]     o_stg
);

    sym_t [NZ-1:0] r_stg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg <= '0;
        end else begin
            r_stg[0] <= i_head;
            for (int i = 1; i < NZ; i++) begin
                r_stg[i] <= r_stg[i-1];
            end
            // Tail load wins over the plain shift (B of B00V).
            if (i_tail_ld) begin
                r_stg[NZ-1] <= i_tail;
            end
        end
    end

    assign o_stg = r_stg;

endmodule

// File: rtl/hdb3sub.sv
// HDB3 (NZ=4) / B3ZS (NZ=3) zero substitution after the AMI encoder.
// Ports: clk, rst (async, active-high); ipos/ineg AMI input; opos/oneg
// registered line output; ierr (only with HDB3SUB_VIOLCHK_EN) input
// violation pulse. Optional feature macro: HDB3SUB_VIOLCHK_EN.
module hdb3sub
    import hdb3_pkg::*;
#(
    parameter int NZ = NZ_HDB3
) (
    input  logic clk,
    input  logic rst,
    input  logic ipos,
    input  logic ineg,
    output logic opos,
    output logic oneg
`ifdef HDB3SUB_VIOLCHK_EN
   ,output logic ierr
`endif
);

    sym_t [NZ-1:0] w_stg;

    logic r_inv;
    logic r_par;
    logic r_lastpol;

    logic w_in_mark;
    logic w_in_pol;
    logic w_map_pol;
    logic w_zero_win;
    logic w_det;
    logic w_b00v;
    logic w_vpol;
    sym_t w_head;
    sym_t w_tail;

    // ipos=ineg=1 is not a mark, so it behaves as a zero.
    assign w_in_mark = ipos ^ ineg;
    assign w_in_pol  = ineg;
    assign w_map_pol = w_in_pol ^ r_inv;

    always_comb begin
        w_zero_win = 1'b1;
        for (int i = 0; i < NZ - 1; i++) begin
            if (w_stg[i] != SYM_ZERO) begin
                w_zero_win = 1'b0;
            end
        end
    end

    assign w_det  = ~w_in_mark & w_zero_win;
    assign w_b00v = w_det & ~r_par;
    // 000V reuses the last polarity; B00V flips it for both B and V.
    assign w_vpol = w_b00v ? ~r_lastpol : r_lastpol;
    assign w_tail = pol2sym(~r_lastpol);

    always_comb begin
        w_head = SYM_ZERO;
        if (w_det) begin
            w_head = pol2sym(w_vpol);
        end else if (w_in_mark) begin
            w_head = pol2sym(w_map_pol);
        end
    end

    hdb3dline #(
        .NZ(NZ)
    ) u_dline (
        .clk       (clk),
        .rst       (rst),
        .i_head    (w_head),
        .i_tail_ld (w_b00v),
        .i_tail    (w_tail),
        .o_stg     (w_stg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv     <= 1'b0;
            r_par     <= 1'b0;
            r_lastpol <= POL_NEG;
        end else if (w_det) begin
            r_lastpol <= w_vpol;
            r_par     <= 1'b0;
            // Restores alternation of the following AMI marks after B00V.
            if (w_b00v) begin
                r_inv <= ~r_inv;
            end
        end else if (w_in_mark) begin
            r_lastpol <= w_map_pol;
            r_par     <= ~r_par;
        end
    end

    assign opos = w_stg[NZ-1][1];
    assign oneg = w_stg[NZ-1][0];

`ifdef HDB3SUB_VIOLCHK_EN
    logic r_lastin;
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastin <= POL_NEG;
            r_err    <= 1'b0;
        end else begin
            r_err <= (ipos & ineg) | (w_in_mark & (w_in_pol == r_lastin));
            if (w_in_mark) begin
                r_lastin <= w_in_pol;
            end
        end
    end

    assign ierr = r_err;
`endif

endmodule

// File: tb/tb_hdb3sub.sv
// Self-checking bench for hdb3sub: stream-level substitution model,
// hand-computed sequences, async reset and randomized traffic.
module tb_hdb3sub;

    localparam int NZ = 4;

    logic clk = 1'b0;
    logic rst;
    logic ipos;
    logic ineg;
    logic opos;
    logic oneg;
`ifdef HDB3SUB_VIOLCHK_EN
    logic ierr;
`endif

    always #5 clk = ~clk;

    hdb3sub #(
        .NZ(NZ)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ipos (ipos),
        .ineg (ineg),
        .opos (opos),
        .oneg (oneg)
`ifdef HDB3SUB_VIOLCHK_EN
       ,.ierr (ierr)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic       chk_en = 1'b0;
    logic [1:0] exp_sym;
    logic       exp_err;

    // Model: the whole line stream as a list; element j is the symbol
    // on the output after the j-th edge since reset. The NZ-1 leading
    // zeros are the flushed pipeline contents after reset.
    logic [1:0] q[$];
    bit m_inv, m_par, m_lp, m_lastin;
    int m_j;

    function automatic logic [1:0] psym(input bit p);
        return p ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] ch2sym(input byte c);
        case (c)
            "+": return 2'b10;
            "-": return 2'b01;
            "X": return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NZ - 1; i++) q.push_back(2'b00);
        m_inv = 0;
        m_par = 0;
        m_lp = 1;
        m_lastin = 1;
        m_j = 0;
    endtask

    task automatic model_step(input logic [1:0] s);
        bit mark;
        bit run;
        int L;
        mark = (s == 2'b10) || (s == 2'b01);
        exp_err = (s == 2'b11) || (mark && ((s == 2'b01) == m_lastin));
        if (mark) begin
            m_lastin = (s == 2'b01);
            m_lp = m_lastin ^ m_inv;
            m_par = !m_par;
            q.push_back(psym(m_lp));
        end else begin
            L = q.size();
            run = 1;
            for (int i = 1; i < NZ; i++)
                if (q[L-i] != 2'b00) run = 0;
            if (!run) begin
                q.push_back(2'b00);
            end else if (m_par) begin
                q.push_back(psym(m_lp));
                m_par = 0;
            end else begin
                m_lp = !m_lp;
                q[L-NZ+1] = psym(m_lp);
                q.push_back(psym(m_lp));
                m_inv = !m_inv;
                m_par = 0;
            end
        end
        exp_sym = q[m_j];
        m_j++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if ({opos, oneg} !== exp_sym) begin
                n_err++;
                $display("FAIL line edge %0d: got %b%b want %b",
                         m_j - 1, opos, oneg, exp_sym);
            end
`ifdef HDB3SUB_VIOLCHK_EN
            n_vec++;
            if (ierr !== exp_err) begin
                n_err++;
                $display("FAIL ierr edge %0d: got %b want %b",
                         m_j - 1, ierr, exp_err);
            end
`endif
        end
    end

    task automatic check0(input string tag);
        n_vec++;
        if ({opos, oneg} !== 2'b00) begin
            n_err++;
            $display("FAIL %s line: got %b%b want 00", tag, opos, oneg);
        end
`ifdef HDB3SUB_VIOLCHK_EN
        n_vec++;
        if (ierr !== 1'b0) begin
            n_err++;
            $display("FAIL %s ierr: got %b want 0", tag, ierr);
        end
`endif
    endtask

    // Called at a negedge; reset rises mid low phase to test async clear.
    task automatic do_reset();
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check0("async_rst");
        @(posedge clk);
        #1;
        check0("held_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic [1:0] s, output logic [1:0] got);
        ipos = s[1];
        ineg = s[0];
        @(posedge clk);
        model_step(s);
        chk_en = 1'b1;
        @(negedge clk);
        got = {opos, oneg};
    endtask

    // Literal check: outputs from edge 'off' onward must spell 'ex'.
    task automatic directed(input string name, input string in,
                            input string ex, input int off);
        logic [1:0] got[$];
        logic [1:0] g;
        logic [1:0] w;
        do_reset();
        for (int i = 0; i < in.len(); i++) begin
            step(ch2sym(in[i]), g);
            got.push_back(g);
        end
        for (int i = 0; i < NZ - 1; i++) begin
            step(2'b10, g);
            got.push_back(g);
        end
        for (int i = 0; i < ex.len(); i++) begin
            w = ch2sym(ex[i]);
            n_vec++;
            if (got[off+i] !== w) begin
                n_err++;
                $display("FAIL %s pos %0d: got %b want %b",
                         name, i, got[off+i], w);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] g;
        logic [1:0] s;
        string post;
        int r;
        rst = 1'b1;
        ipos = 1'b0;
        ineg = 1'b0;
        model_reset();

        directed("idle_zeros", "000000000000", "+00+-00-+00+", 0);
        directed("000V", "+0000-", "+000+-", NZ - 1);
        directed("B00V", "+-0000+", "+-+00+-", NZ - 1);
        directed("long_run", "+000000000", "+000+-00-0", NZ - 1);

        // Reset lands while a fresh V sits at the pipeline head.
        do_reset();
        for (int i = 0; i < 5; i++) step(ch2sym(i == 0 ? "+" : "0"), g);
        do_reset();
        post = "";
        for (int i = 0; i < 8; i++) begin
            step(2'b00, g);
            post = {post, (g == 2'b10) ? "+" : (g == 2'b01) ? "-" : "0"};
        end
        n_vec++;
        if (post != "+00+-00-") begin
            n_err++;
            $display("FAIL rst_mid: got %s want +00+-00-", post);
        end

`ifdef HDB3SUB_VIOLCHK_EN
        directed("illegal", "++X0", "++00", NZ - 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s = (i == 2) ? 2'b11 : 2'b10;
            step(s, g);
            n_vec++;
            if (ierr !== (i != 0)) begin
                n_err++;
                $display("FAIL viol_lit %0d: got %b want %b",
                         i, ierr, (i != 0));
            end
        end
`endif

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            if (r < 2) begin
                do_reset();
            end else begin
                if (r < 120) s = 2'b00;
                else if (r < 158) s = 2'b10;
                else if (r < 196) s = 2'b01;
                else s = 2'b11;
                step(s, g);
            end
        end

        #2;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
